// File: rtl/multi_event_cntr_regs.sv
// multi_event_cntr_regs
//
// Bank of NUM_CNTRS event counters, each CNTR_WIDTH bits wide, served on the UDP register
// ring. Every cycle each counter adds its INPUT_WIDTH-bit increment and subtracts its
// decrement strobe. Counters can be preloaded by a CPU write. Reset-on-read (RESET_ON_READ)
// and saturation (SATURATE) are optional. The ring passes through this block with one cycle of
// latency.
//
// Optional feature: define MULTI_EVENT_CNTR_OVERFLOW_FLAG_EN to add a sticky status register
// at in-block address NUM_CNTRS. Bit i records a wrap or clamp of counter i. Reading the
// register clears it.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   reg_*_in            ring inputs (req, ack, rd_wr_L, addr, data, src)
//   reg_*_out           registered ring outputs
//   updates             per-counter unsigned increment, counter i at [i*INPUT_WIDTH +: INPUT_WIDTH]
//   decrement           per-counter decrement strobe

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module multi_event_cntr_regs #(
    parameter int unsigned UDP_REG_SRC_WIDTH = 2,
    parameter int unsigned TAG               = 0,
    parameter int unsigned REG_ADDR_WIDTH    = 5,
    parameter int unsigned NUM_CNTRS         = 10,
    parameter int unsigned INPUT_WIDTH       = 4,
    parameter int unsigned CNTR_WIDTH        = 32,
    parameter int unsigned RESET_ON_READ     = 0,
    parameter int unsigned SATURATE          = 0
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic                              reg_req_in,
    input  logic                              reg_ack_in,
    input  logic                              reg_rd_wr_L_in,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_in,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_in,

    output logic                              reg_req_out,
    output logic                              reg_ack_out,
    output logic                              reg_rd_wr_L_out,
    output logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_out,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_out,

    input  logic [NUM_CNTRS*INPUT_WIDTH-1:0]  updates,
    input  logic [NUM_CNTRS-1:0]              decrement
);

    localparam int unsigned AW   = `UDP_REG_ADDR_WIDTH;
    localparam int unsigned DW   = `CPCI_NF2_DATA_WIDTH;
    localparam int unsigned TagW = AW - REG_ADDR_WIDTH;
    // Two guard bits: bit CNTR_WIDTH flags overflow, the top bit flags underflow (negative).
    localparam int unsigned ExtW = CNTR_WIDTH + 2;

    localparam logic [TagW-1:0] TagVal = TagW'(TAG);

    // Ring decode
    logic [REG_ADDR_WIDTH-1:0] a;
    logic                      hit, rd_hit, wr_hit, in_range;

    assign a        = reg_addr_in[REG_ADDR_WIDTH-1:0];
    assign hit      = reg_req_in && !reg_ack_in && (reg_addr_in[AW-1:REG_ADDR_WIDTH] == TagVal);
    assign rd_hit   = hit && reg_rd_wr_L_in;
    assign wr_hit   = hit && !reg_rd_wr_L_in;
    assign in_range = (a < REG_ADDR_WIDTH'(NUM_CNTRS));

    // Counter state
    logic [CNTR_WIDTH-1:0] cnt_q [NUM_CNTRS];
    logic [CNTR_WIDTH-1:0] cnt_d [NUM_CNTRS];
    logic [CNTR_WIDTH-1:0] base_v [NUM_CNTRS];
    logic [ExtW-1:0]       sum_v [NUM_CNTRS];
    logic [NUM_CNTRS-1:0]  ovf, unf;
    logic [CNTR_WIDTH-1:0] rd_cnt;

`ifdef MULTI_EVENT_CNTR_OVERFLOW_FLAG_EN
    logic [NUM_CNTRS-1:0] ev;
    logic [NUM_CNTRS-1:0] flags_q, flags_d;
    logic                 status_sel;

    assign status_sel = (a == REG_ADDR_WIDTH'(NUM_CNTRS));
`endif

    always_comb begin
        rd_cnt = '0;
`ifdef MULTI_EVENT_CNTR_OVERFLOW_FLAG_EN
        ev = '0;
`endif
        for (int i = 0; i < NUM_CNTRS; i++) begin
            if (a == REG_ADDR_WIDTH'(i)) begin
                rd_cnt = cnt_q[i];
            end
            // Reset-on-read restarts from zero but keeps this cycle's delta.
            if (rd_hit && (a == REG_ADDR_WIDTH'(i)) && (RESET_ON_READ != 0)) begin
                base_v[i] = '0;
            end else begin
                base_v[i] = cnt_q[i];
            end
            sum_v[i] = ExtW'(base_v[i]) + ExtW'(updates[i*INPUT_WIDTH +: INPUT_WIDTH])
                     - ExtW'(decrement[i]);
            unf[i] = sum_v[i][ExtW-1];
            ovf[i] = (sum_v[i][ExtW-1:ExtW-2] == 2'b01);

            if ((SATURATE != 0) && ovf[i]) begin
                cnt_d[i] = '1;
            end else if ((SATURATE != 0) && unf[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = sum_v[i][CNTR_WIDTH-1:0];
            end
`ifdef MULTI_EVENT_CNTR_OVERFLOW_FLAG_EN
            ev[i] = ovf[i] | unf[i];
`endif
            // A CPU write overrides the update; no wrap can happen on the written value.
            if (wr_hit && (a == REG_ADDR_WIDTH'(i))) begin
                cnt_d[i] = reg_data_in[CNTR_WIDTH-1:0];
`ifdef MULTI_EVENT_CNTR_OVERFLOW_FLAG_EN
                ev[i]    = 1'b0;
`endif
            end
        end
    end

`ifdef MULTI_EVENT_CNTR_OVERFLOW_FLAG_EN
    // Events landing in the same cycle as the clearing read stay set.
    always_comb begin
        flags_d = flags_q | ev;
        if (rd_hit && status_sel) begin
            flags_d = ev;
        end
    end
`endif

    // Ring output next-state
    logic [DW-1:0] data_d;
    logic          ack_d;

    always_comb begin
        data_d = reg_data_in;
        ack_d  = reg_ack_in;
        if (hit) begin
            ack_d = 1'b1;
            if (reg_rd_wr_L_in) begin
                if (in_range) begin
                    data_d                 = '0;
                    data_d[CNTR_WIDTH-1:0] = rd_cnt;
                end
`ifdef MULTI_EVENT_CNTR_OVERFLOW_FLAG_EN
                else if (status_sel) begin
                    data_d                = '0;
                    data_d[NUM_CNTRS-1:0] = flags_q;
                end
`endif
                else begin
                    data_d = DW'(32'hDEAD_BEEF);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
            for (int i = 0; i < NUM_CNTRS; i++) begin
                cnt_q[i] <= '0;
            end
`ifdef MULTI_EVENT_CNTR_OVERFLOW_FLAG_EN
            flags_q <= '0;
`endif
        end else begin
            reg_req_out     <= reg_req_in;
            reg_ack_out     <= ack_d;
            reg_rd_wr_L_out <= reg_rd_wr_L_in;
            reg_addr_out    <= reg_addr_in;
            reg_data_out    <= data_d;
            reg_src_out     <= reg_src_in;
            for (int i = 0; i < NUM_CNTRS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`ifdef MULTI_EVENT_CNTR_OVERFLOW_FLAG_EN
            flags_q <= flags_d;
`endif
        end
    end

endmodule

// File: tb/tb_multi_event_cntr_regs.sv
// Testbench for multi_event_cntr_regs.
// Two instances share the ring and event inputs:
//   dut0: TAG=0, wrapping, no reset-on-read.
//   dut1: TAG=1, saturating, reset-on-read.
// Each DUT treats the other's requests as foreign traffic.

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_multi_event_cntr_regs;

    localparam int AW = `UDP_REG_ADDR_WIDTH;
    localparam int DW = `CPCI_NF2_DATA_WIDTH;
    localparam int NC = 10;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req_in = 1'b0, ack_in = 1'b0, rdwr_in = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic [DW-1:0] data_in = '0;
    logic [1:0]    src_in = '0;
    logic [NC*IW-1:0] updates = '0;
    logic [NC-1:0]    decrement = '0;

    logic          req0, ack0, rdwr0, req1, ack1, rdwr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic [1:0]    src0, src1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multi_event_cntr_regs #(.TAG(0), .RESET_ON_READ(0), .SATURATE(0)) dut0 (
        .clk(clk), .reset(reset),
        .reg_req_in(req_in), .reg_ack_in(ack_in), .reg_rd_wr_L_in(rdwr_in),
        .reg_addr_in(addr_in), .reg_data_in(data_in), .reg_src_in(src_in),
        .reg_req_out(req0), .reg_ack_out(ack0), .reg_rd_wr_L_out(rdwr0),
        .reg_addr_out(addr0), .reg_data_out(data0), .reg_src_out(src0),
        .updates(updates), .decrement(decrement)
    );

    multi_event_cntr_regs #(.TAG(1), .RESET_ON_READ(1), .SATURATE(1)) dut1 (
        .clk(clk), .reset(reset),
        .reg_req_in(req_in), .reg_ack_in(ack_in), .reg_rd_wr_L_in(rdwr_in),
        .reg_addr_in(addr_in), .reg_data_in(data_in), .reg_src_in(src_in),
        .reg_req_out(req1), .reg_ack_out(ack1), .reg_rd_wr_L_out(rdwr1),
        .reg_addr_out(addr1), .reg_data_out(data1), .reg_src_out(src1),
        .updates(updates), .decrement(decrement)
    );

    // One ring transaction. On return (1 time unit after the edge) the outputs hold the result.
    task automatic ring(input logic rd, input logic [17:0] tag, input logic [4:0] a,
                        input logic [31:0] d, input logic ack);
        req_in  = 1'b1;
        ack_in  = ack;
        rdwr_in = rd;
        addr_in = {tag, a};
        data_in = d;
        src_in  = 2'b10;
        @(posedge clk);
        #1;
        req_in  = 1'b0;
        ack_in  = 1'b0;
        rdwr_in = 1'b0;
        addr_in = '0;
        data_in = '0;
        src_in  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({req0, ack0, rdwr0, addr0, data0, src0} !== '0) begin
            $display("FAIL reset_out0: got %h required 0", {req0, ack0, rdwr0, addr0, data0, src0});
            n_fail++;
        end
        n_tests++;
        if ({req1, ack1, rdwr1, addr1, data1, src1} !== '0) begin
            $display("FAIL reset_out1: got %h required 0", {req1, ack1, rdwr1, addr1, data1, src1});
            n_fail++;
        end
        reset = 1'b0;
    endtask

    task automatic test_count();
        for (int k = 0; k < 3; k++) begin
            updates[3:0] = 4'd5;
            decrement[0] = (k == 1);
            @(posedge clk);
            #1;
        end
        updates   = '0;
        decrement = '0;
        ring(1'b1, 18'd0, 5'd0, 32'h0, 1'b0);
        n_tests++;
        if (ack0 !== 1'b1 || data0 !== 32'd14) begin
            $display("FAIL count_dut0: got ack=%b data=%h required ack=1 data=0000000e", ack0, data0);
            n_fail++;
        end
        ring(1'b1, 18'd1, 5'd0, 32'h0, 1'b0);
        n_tests++;
        if (ack1 !== 1'b1 || data1 !== 32'd14) begin
            $display("FAIL count_dut1: got ack=%b data=%h required ack=1 data=0000000e", ack1, data1);
            n_fail++;
        end
        for (int i = 1; i < NC; i++) begin
            ring(1'b1, 18'd0, 5'(i), 32'h0, 1'b0);
            n_tests++;
            if (data0 !== 32'd0) begin
                $display("FAIL idle_cntr%0d: got %h required 00000000", i, data0);
                n_fail++;
            end
        end
    endtask

    task automatic test_overflow();
        ring(1'b0, 18'd0, 5'd2, 32'hFFFF_FFFE, 1'b0);
        ring(1'b0, 18'd1, 5'd2, 32'hFFFF_FFFE, 1'b0);
        updates[11:8] = 4'd3;
        @(posedge clk);
        #1;
        updates = '0;
        ring(1'b1, 18'd0, 5'd2, 32'h0, 1'b0);
        n_tests++;
        if (data0 !== 32'd1) begin
            $display("FAIL wrap_up: got %h required 00000001", data0);
            n_fail++;
        end
        ring(1'b1, 18'd1, 5'd2, 32'h0, 1'b0);
        n_tests++;
        if (data1 !== 32'hFFFF_FFFF) begin
            $display("FAIL sat_up: got %h required ffffffff", data1);
            n_fail++;
        end
`ifdef MULTI_EVENT_CNTR_OVERFLOW_FLAG_EN
        ring(1'b1, 18'd0, 5'd10, 32'h0, 1'b0);
        n_tests++;
        if (data0 !== 32'h4) begin
            $display("FAIL flag_wrap: got %h required 00000004", data0);
            n_fail++;
        end
        ring(1'b1, 18'd0, 5'd10, 32'h0, 1'b0);
        n_tests++;
        if (data0 !== 32'h0) begin
            $display("FAIL flag_clear: got %h required 00000000", data0);
            n_fail++;
        end
        ring(1'b1, 18'd1, 5'd10, 32'h0, 1'b0);
        n_tests++;
        if (data1 !== 32'h4) begin
            $display("FAIL flag_clamp: got %h required 00000004", data1);
            n_fail++;
        end
`else
        ring(1'b1, 18'd0, 5'd10, 32'h0, 1'b0);
        n_tests++;
        if (ack0 !== 1'b1 || data0 !== 32'hDEAD_BEEF) begin
            $display("FAIL no_status_reg: got ack=%b data=%h required ack=1 data=deadbeef", ack0, data0);
            n_fail++;
        end
`endif
    endtask

    task automatic test_underflow();
        decrement[1] = 1'b1;
        @(posedge clk);
        #1;
        decrement = '0;
        ring(1'b1, 18'd0, 5'd1, 32'h0, 1'b0);
        n_tests++;
        if (data0 !== 32'hFFFF_FFFF) begin
            $display("FAIL wrap_down: got %h required ffffffff", data0);
            n_fail++;
        end
        ring(1'b1, 18'd1, 5'd1, 32'h0, 1'b0);
        n_tests++;
        if (data1 !== 32'd0) begin
            $display("FAIL sat_down: got %h required 00000000", data1);
            n_fail++;
        end
`ifdef MULTI_EVENT_CNTR_OVERFLOW_FLAG_EN
        ring(1'b1, 18'd0, 5'd10, 32'h0, 1'b0);
        n_tests++;
        if (data0 !== 32'h2) begin
            $display("FAIL flag_under0: got %h required 00000002", data0);
            n_fail++;
        end
        // Clamp again in the same cycle as the clearing read: the flag must survive.
        decrement[1] = 1'b1;
        ring(1'b1, 18'd1, 5'd10, 32'h0, 1'b0);
        decrement = '0;
        n_tests++;
        if (data1 !== 32'h2) begin
            $display("FAIL flag_under1: got %h required 00000002", data1);
            n_fail++;
        end
        ring(1'b1, 18'd1, 5'd10, 32'h0, 1'b0);
        n_tests++;
        if (data1 !== 32'h2) begin
            $display("FAIL flag_survive: got %h required 00000002", data1);
            n_fail++;
        end
        ring(1'b1, 18'd1, 5'd10, 32'h0, 1'b0);
        n_tests++;
        if (data1 !== 32'h0) begin
            $display("FAIL flag_after_survive: got %h required 00000000", data1);
            n_fail++;
        end
`endif
    endtask

    task automatic test_reset_on_read();
        ring(1'b0, 18'd1, 5'd4, 32'd7, 1'b0);
        updates[19:16] = 4'd2;
        ring(1'b1, 18'd1, 5'd4, 32'h0, 1'b0);
        updates = '0;
        n_tests++;
        if (data1 !== 32'd7) begin
            $display("FAIL ror_first: got %h required 00000007", data1);
            n_fail++;
        end
        ring(1'b1, 18'd1, 5'd4, 32'h0, 1'b0);
        n_tests++;
        if (data1 !== 32'd2) begin
            $display("FAIL ror_second: got %h required 00000002", data1);
            n_fail++;
        end
        // The wrapping instance must not clear on read.
        ring(1'b0, 18'd0, 5'd4, 32'd7, 1'b0);
        ring(1'b1, 18'd0, 5'd4, 32'h0, 1'b0);
        ring(1'b1, 18'd0, 5'd4, 32'h0, 1'b0);
        n_tests++;
        if (data0 !== 32'd7) begin
            $display("FAIL no_ror: got %h required 00000007", data0);
            n_fail++;
        end
    endtask

    task automatic test_write_and_oor();
        updates[23:20] = 4'd9;
        ring(1'b0, 18'd1, 5'd5, 32'd100, 1'b0);
        ring(1'b0, 18'd0, 5'd5, 32'd100, 1'b0);
        updates = '0;
        n_tests++;
        if (ack0 !== 1'b1 || data0 !== 32'd100) begin
            $display("FAIL write_ack: got ack=%b data=%h required ack=1 data=00000064", ack0, data0);
            n_fail++;
        end
        ring(1'b1, 18'd0, 5'd5, 32'h0, 1'b0);
        n_tests++;
        if (data0 !== 32'd100) begin
            $display("FAIL write_wins: got %h required 00000064", data0);
            n_fail++;
        end
        // dut1 was written one cycle earlier and took the +9 during dut0's write.
        ring(1'b1, 18'd1, 5'd5, 32'h0, 1'b0);
        n_tests++;
        if (data1 !== 32'd109) begin
            $display("FAIL write_then_update: got %h required 0000006d", data1);
            n_fail++;
        end
        ring(1'b1, 18'd0, 5'd11, 32'h0, 1'b0);
        n_tests++;
        if (ack0 !== 1'b1 || data0 !== 32'hDEAD_BEEF) begin
            $display("FAIL oor_read: got ack=%b data=%h required ack=1 data=deadbeef", ack0, data0);
            n_fail++;
        end
        ring(1'b0, 18'd0, 5'd11, 32'h55, 1'b0);
        n_tests++;
        if (ack0 !== 1'b1 || data0 !== 32'h55) begin
            $display("FAIL oor_write: got ack=%b data=%h required ack=1 data=00000055", ack0, data0);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        ring(1'b0, 18'd0, 5'd6, 32'h11, 1'b0);
        ring(1'b0, 18'd0, 5'd7, 32'h22, 1'b0);
        ring(1'b1, 18'd0, 5'd6, 32'h0, 1'b0);
        n_tests++;
        if (data0 !== 32'h11) begin
            $display("FAIL b2b_0: got %h required 00000011", data0);
            n_fail++;
        end
        ring(1'b1, 18'd0, 5'd7, 32'h0, 1'b0);
        n_tests++;
        if (data0 !== 32'h22) begin
            $display("FAIL b2b_1: got %h required 00000022", data0);
            n_fail++;
        end
        ring(1'b1, 18'd0, 5'd6, 32'h0, 1'b0);
        n_tests++;
        if (data0 !== 32'h11) begin
            $display("FAIL b2b_2: got %h required 00000011", data0);
            n_fail++;
        end
    endtask

    task automatic test_passthrough();
        ring(1'b1, 18'd5, 5'd0, 32'h1234_5678, 1'b0);
        n_tests++;
        if ({req0, ack0, rdwr0, addr0, data0, src0} !== {3'b101, {18'd5, 5'd0}, 32'h1234_5678, 2'b10}) begin
            $display("FAIL pass_tag0: got %h required %h", {req0, ack0, rdwr0, addr0, data0, src0},
                     {3'b101, {18'd5, 5'd0}, 32'h1234_5678, 2'b10});
            n_fail++;
        end
        n_tests++;
        if ({req1, ack1, rdwr1, addr1, data1, src1} !== {3'b101, {18'd5, 5'd0}, 32'h1234_5678, 2'b10}) begin
            $display("FAIL pass_tag1: got %h required %h", {req1, ack1, rdwr1, addr1, data1, src1},
                     {3'b101, {18'd5, 5'd0}, 32'h1234_5678, 2'b10});
            n_fail++;
        end
        ring(1'b1, 18'd0, 5'd6, 32'hCAFE_F00D, 1'b1);
        n_tests++;
        if ({req0, ack0, rdwr0, addr0, data0, src0} !== {3'b111, {18'd0, 5'd6}, 32'hCAFE_F00D, 2'b10}) begin
            $display("FAIL pass_acked: got %h required %h", {req0, ack0, rdwr0, addr0, data0, src0},
                     {3'b111, {18'd0, 5'd6}, 32'hCAFE_F00D, 2'b10});
            n_fail++;
        end
        // Reset lands on an in-flight request.
        req_in  = 1'b1;
        rdwr_in = 1'b1;
        addr_in = {18'd0, 5'd5};
        reset   = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (req0 !== 1'b0 || req1 !== 1'b0) begin
            $display("FAIL reset_midreq: got req0=%b req1=%b required 0 0", req0, req1);
            n_fail++;
        end
        reset   = 1'b0;
        req_in  = 1'b0;
        rdwr_in = 1'b0;
        addr_in = '0;
        ring(1'b1, 18'd0, 5'd5, 32'h0, 1'b0);
        n_tests++;
        if (data0 !== 32'd0) begin
            $display("FAIL reset_clears: got %h required 00000000", data0);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_overflow();
        test_underflow();
        test_reset_on_read();
        test_write_and_oor();
        test_back_to_back();
        test_passthrough();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the run gets stuck.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/multi_event_cntr_regs.md
Name: multi_event_cntr_regs

Overview:
Parametrised successor to the fixed single-bit counter register blocks used in output_port_lookup and similar modules. It holds NUM_CNTRS counters, each CNTR_WIDTH bits wide. Every counter accepts a multi-bit increment and a decrement strobe on every clock, so there is no minimum update interval. Counters are served on the UDP register ring and support CPU write (preload), optional reset-on-read and optional saturation. It sits in the register ring chain next to the datapath module whose events it counts.

Parameters:
UDP_REG_SRC_WIDTH, 2, width of reg_src_in/out.
TAG, 0, block tag compared against reg_addr_in[`UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH].
REG_ADDR_WIDTH, 5, width of the in-block word address.
NUM_CNTRS, 10, number of counters; must be ≤ 2**REG_ADDR_WIDTH - 1.
INPUT_WIDTH, 4, width of each counter's increment field.
CNTR_WIDTH, 32, counter width; must be ≤ `CPCI_NF2_DATA_WIDTH.
RESET_ON_READ, 0, 1 = a counter clears when it is read.
SATURATE, 0, 1 = clamp at the limits; 0 = wrap modulo 2**CNTR_WIDTH.

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
reg_req_in  in  1  ring request
reg_ack_in  in  1  ring acknowledge from upstream
reg_rd_wr_L_in  in  1  1 = read, 0 = write
reg_addr_in  in  `UDP_REG_ADDR_WIDTH  ring address
reg_data_in  in  `CPCI_NF2_DATA_WIDTH  ring data
reg_src_in  in  UDP_REG_SRC_WIDTH  ring source
reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out  out  same widths as inputs  registered ring outputs
updates  in  NUM_CNTRS*INPUT_WIDTH  unsigned increment; counter i uses bits [i*INPUT_WIDTH +: INPUT_WIDTH]
decrement  in  NUM_CNTRS  bit i = 1: counter i subtracts 1 this cycle

Behaviour:
- Clocking: one clock (clk). reset is synchronous and active-high. On reset, all counters and all ring outputs go to 0.
- Per-cycle update for counter i: next = cnt + upd_i - dec_i.
  - The arithmetic is done at CNTR_WIDTH+2 bits to detect overflow and underflow.
  - SATURATE=0: the result is truncated modulo 2**CNTR_WIDTH.
  - SATURATE=1: the result clamps to 2**CNTR_WIDTH-1 on overflow and to 0 on underflow.
  - upd=0 with dec=0 leaves the counter unchanged.
- Address decode: a hit requires reg_req_in=1, reg_ack_in=0, and an upper address equal to TAG. Let a = reg_addr_in[REG_ADDR_WIDTH-1:0].
- Ring latency: exactly 1 cycle. All *_out signals are registered copies of the *_in signals, except on a hit:
  - reg_ack_out is 1.
  - On a read with a < NUM_CNTRS: reg_data_out = cnt[a] as it was before this cycle's update, zero-extended.
  - On a write: reg_data_out = reg_data_in.
  - On any access with a ≥ NUM_CNTRS (and not the optional status address): reads return 32'hDEAD_BEEF and writes are ignored. Both are still acknowledged.
- Write to counter a: cnt[a] <= reg_data_in[CNTR_WIDTH-1:0]. That counter's update in the same cycle is discarded (write wins). Other counters update normally.
- Read with RESET_ON_READ=1: cnt[a] <= this cycle's delta only (0 + upd - dec, clamped at 0 if SATURATE=1, else wrapped). No event is lost. Reads never modify counters when RESET_ON_READ=0.
- Requests that do not hit, and requests that are already acknowledged, pass through unmodified with 1-cycle latency. Back-to-back ring requests are accepted every cycle.
- Reset asserted mid-transaction: the in-flight ring output is dropped (req_out=0 on the next cycle) and all counters are cleared.

Optional Feature:
Macro MULTI_EVENT_CNTR_OVERFLOW_FLAG_EN.
- Defined: adds a sticky status register at in-block address NUM_CNTRS.
  - Bit i is set whenever counter i wraps (SATURATE=0) or clamps (SATURATE=1), in either direction.
  - A read of this register returns the flags (bits ≥ NUM_CNTRS read 0) and clears them.
  - A flag event in the same cycle as the read survives: the flag stays set after the read.
  - Writes to this register are acknowledged and ignored.
  - Reset clears all flags.
- Undefined: no flag logic exists. Address NUM_CNTRS behaves like any other out-of-range address (reads return DEAD_BEEF).

Test Plan:
1. Reset, then drive updates[3:0]=4'd5 on counter 0 for 3 cycles with decrement[0] pulsed once; read addr 0 → 32'd14; all other counters read 0.
2. Write counter 2 = 32'hFFFF_FFFE, then drive upd=3. SATURATE=0 → reads 1, flag bit 2 set if the macro is enabled. SATURATE=1 → reads 32'hFFFF_FFFF.
3. Counter 1 = 0 with decrement[1]=1. SATURATE=1 → stays 0. SATURATE=0 → reads 32'hFFFF_FFFF.
4. RESET_ON_READ=1, counter 4 = 7, read in the same cycle as upd=2 → returns 7; a second read → 2.
5. Write 32'd100 to counter 5 in the same cycle as upd=9 → reads 100. Read addr NUM_CNTRS+1 → ack=1, data=32'hDEAD_BEEF.
6. Request with a different TAG, and a request with reg_ack_in=1 → outputs match the inputs 1 cycle later with ack unchanged; assert reset mid-request → reg_req_out=0 on the next cycle.
